prog_loader: RTL and testbench

//  Serial program loader and writer for the RAT MCU's 1024x18 program memory.

---
 rtl/prog_loader_if.sv | 24 ++
 rtl/prog_loader.sv | 79 +++++++
 tb/tb_prog_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and program-memory write/status bundle of the RAT program loader
interface prog_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_waddr;
  logic [DATA_W-1:0] prog_wdata;
  logic              mcu_hold;
  logic              busy;
  logic              load_done;
  logic              load_err;
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, prog_we, prog_waddr, prog_wdata, mcu_hold, busy, load_done, load_err
  );
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, prog_we, prog_waddr, prog_wdata, mcu_hold, busy, load_done, load_err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a sync/count/3-byte-word/XOR-checksum frame into program memory, holding the MCU in reset meanwhile
module prog_loader #(
  parameter int          ADDR_W      = 10,
  parameter int          DATA_W      = 18,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input logic         prog_clk,
  input logic         rst,
  prog_loader_if.slave bus
);
  typedef enum logic [3:0] {IDLE, CNT_HI, CNT_LO, B2, B1, B0, WRITE, CHK, DONE, ERR} state_t;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t            state, nxt;
  logic [TW-1:0]     timer;
  logic [ADDR_W-1:0] cnt, waddr;
  logic [7:0]        chk, b2, b1;
  logic [23:0]       word;
  logic              acc, sync, timed, tout;
  assign bus.rx_ready  = state != WRITE && state != DONE;
  assign bus.prog_we   = state == WRITE;
  assign bus.busy      = state != IDLE && state != ERR;
  assign bus.load_done = state == DONE;
  assign bus.load_err  = state == ERR;
  assign acc   = bus.rx_valid & bus.rx_ready;
  assign sync  = acc && bus.rx_data == SYNC_BYTE;
  assign timed = state inside {CNT_HI, CNT_LO, B2, B1, B0, CHK};
  assign tout  = timed && !acc && timer == TW'(TIMEOUT_CYC - 1);
  assign word  = {b2, b1, bus.rx_data};
  always_comb begin
    nxt = state;
    case (state)
      IDLE, ERR: nxt = sync ? CNT_HI : state;
      CNT_HI:    nxt = acc ? CNT_LO : state;
      CNT_LO:    nxt = acc ? B2 : state;
      B2:        nxt = acc ? B1 : state;
      B1:        nxt = acc ? B0 : state;
      B0:        nxt = acc ? WRITE : state;
      WRITE:     nxt = waddr == cnt ? CHK : B2;
      CHK:       nxt = acc ? (bus.rx_data == chk ? DONE : ERR) : state;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (tout) nxt = ERR;
  end
  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      timer          <= '0;
      cnt            <= '0;
      waddr          <= '0;
      chk            <= '0;
      b2             <= '0;
      b1             <= '0;
      bus.prog_waddr <= '0;
      bus.prog_wdata <= '0;
      bus.mcu_hold   <= 1'b0;
    end else begin
      state <= nxt;
      timer <= (acc || !timed) ? '0 : timer + 1'b1;
      if (sync && (state == IDLE || state == ERR)) begin
        bus.mcu_hold <= 1'b1;
        chk          <= '0;
        waddr        <= '0;
      end
      if (state == DONE) bus.mcu_hold <= 1'b0;
      if (acc && state inside {CNT_HI, CNT_LO, B2, B1, B0}) chk <= chk ^ bus.rx_data;
      if (acc && state == CNT_HI) cnt[ADDR_W-1:8] <= bus.rx_data[ADDR_W-9:0];
      if (acc && state == CNT_LO) cnt[7:0] <= bus.rx_data;
      if (acc && state == B2) b2 <= bus.rx_data;
      if (acc && state == B1) b1 <= bus.rx_data;
      if (acc && state == B0) begin
        bus.prog_waddr <= waddr;
        bus.prog_wdata <= word[DATA_W-1:0];
      end
      if (state == WRITE) waddr <= waddr + 1'b1;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frame stimulus with an event scoreboard for prog_loader
module tb_prog_loader;
  localparam int AW = 10, DW = 18, TO = 40;
  typedef struct {int kind; logic [AW-1:0] a; logic [DW-1:0] d;} ev_t;
  logic prog_clk = 1'b0;
  logic rst = 1'b1;
  ev_t exp_q[$];
  logic [DW-1:0] words[$];
  int vectors = 0, errors = 0, nwrites = 0;
  bit err_q = 1'b0, junk = 1'b0;

  always #5 prog_clk = ~prog_clk;

  prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (.prog_clk(prog_clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic see(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == 0 && e.kind == 0) begin
        check("prog_waddr", a, e.a);
        check("prog_wdata", d, e.d);
      end
    end
  endtask

  always @(negedge prog_clk) begin
    if (!rst) begin
      if (bus.prog_we) begin
        nwrites++;
        check("rx_ready_in_write", bus.rx_ready, 0);
        see(0, bus.prog_waddr, bus.prog_wdata);
      end
      if (bus.load_done) begin
        check("hold_during_done", bus.mcu_hold, 1);
        see(1, '0, '0);
      end
      if (bus.load_err && !err_q) see(2, '0, '0);
    end
    err_q = bus.load_err;
  end

  function automatic ev_t wr_ev(input int i, input logic [DW-1:0] d);
    ev_t e;
    e.kind = 0;
    e.a = AW'(i);
    e.d = d;
    return e;
  endfunction

  function automatic ev_t st_ev(input int k);
    ev_t e;
    e.kind = k;
    e.a = '0;
    e.d = '0;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit r;
    r = 1'b0;
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    for (int t = 0; t < 100 && !r; t++) begin
      @(negedge prog_clk);
      r = bus.rx_ready;
      @(posedge prog_clk);
      #1;
    end
    if (!r) check("rx_ready_timeout", 0, 1);
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(posedge prog_clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap);
    logic [23:0] x;
    x = {junk ? 6'($urandom) : 6'd0, w};
    send_byte(x[23:16], gap);
    send_byte(x[15:8], gap);
    send_byte(x[7:0], gap);
  endtask

  task automatic send_frame(input bit bad, input int maxgap);
    logic [7:0] bytes[$];
    logic [7:0] c;
    logic [AW-1:0] cnt;
    logic [23:0] x;
    c = 8'h00;
    cnt = AW'(words.size() - 1);
    bytes.push_back(8'hA5);
    bytes.push_back({junk ? 6'($urandom) : 6'd0, cnt[9:8]});
    bytes.push_back(cnt[7:0]);
    foreach (words[i]) begin
      x = {junk ? 6'($urandom) : 6'd0, words[i]};
      bytes.push_back(x[23:16]);
      bytes.push_back(x[15:8]);
      bytes.push_back(x[7:0]);
      exp_q.push_back(wr_ev(i, words[i]));
    end
    for (int i = 1; i < bytes.size(); i++) c ^= bytes[i];
    bytes.push_back(bad ? 8'h00 : c);
    exp_q.push_back(st_ev(bad ? 2 : 1));
    foreach (bytes[i]) send_byte(bytes[i], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(posedge prog_clk);
      t++;
    end
    check("events_outstanding", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge prog_clk);
    #1;
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, bus.prog_we, 0);
    check({tag, "_waddr"}, bus.prog_waddr, 0);
    check({tag, "_wdata"}, bus.prog_wdata, 0);
    check({tag, "_hold"}, bus.mcu_hold, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.load_done, 0);
    check({tag, "_err"}, bus.load_err, 0);
  endtask

  initial begin
    int w0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    #12;
    check_all_zero("reset");
    @(negedge prog_clk);
    rst = 1'b0;
    @(posedge prog_clk);
    #1;
    // good two-word frame, then the same frame with a zero checksum
    words = '{18'h12345, 18'h00011};
    send_frame(1'b0, 0);
    wait_drain();
    check("t1_hold", bus.mcu_hold, 0);
    check("t1_err", bus.load_err, 0);
    send_frame(1'b1, 1);
    wait_drain();
    check("t2_err", bus.load_err, 1);
    check("t2_hold", bus.mcu_hold, 1);
    check("t2_busy", bus.busy, 0);
    send_frame(1'b0, 2);
    wait_drain();
    check("t2_err_cleared", bus.load_err, 0);
    check("t2_hold", bus.mcu_hold, 0);
    // full-depth frame with junk in the ignored upper bits
    junk = 1'b1;
    rand_words(1024);
    w0 = nwrites;
    send_frame(1'b0, 1);
    wait_drain();
    check("t3_write_count", nwrites - w0, 1024);
    check("t3_hold", bus.mcu_hold, 0);
    // back-to-back bytes with sync values embedded in the data
    rand_words(6);
    foreach (words[i]) words[i][15:8] = 8'hA5;
    words[2][7:0] = 8'hA5;
    send_frame(1'b0, 0);
    wait_drain();
    check("t4_hold", bus.mcu_hold, 0);
    // stall after the B1 byte of the second word
    junk = 1'b0;
    rand_words(2);
    exp_q.push_back(wr_ev(0, words[0]));
    exp_q.push_back(st_ev(2));
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(words[0], 0);
    send_byte({6'd0, words[1][17:16]}, 0);
    send_byte(words[1][15:8], 0);
    bus.rx_valid = 1'b0;
    repeat (TO + 10) @(posedge prog_clk);
    #1;
    check("t5_err", bus.load_err, 1);
    check("t5_hold", bus.mcu_hold, 1);
    check("t5_busy", bus.busy, 0);
    check("t5_events_outstanding", exp_q.size(), 0);
    send_byte(8'h37, 3);
    check("t5_drop_err", bus.load_err, 1);
    check("t5_drop_busy", bus.busy, 0);
    rand_words(3);
    send_frame(1'b0, 1);
    wait_drain();
    check("t5_recover_err", bus.load_err, 0);
    // asynchronous reset after two of four words are written
    rand_words(4);
    exp_q.push_back(wr_ev(0, words[0]));
    exp_q.push_back(wr_ev(1, words[1]));
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word(words[0], 0);
    send_word(words[1], 0);
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    check("t6_events_outstanding", exp_q.size(), 0);
    exp_q.delete();
    @(negedge prog_clk);
    rst = 1'b0;
    @(posedge prog_clk);
    #1;
    rand_words(5);
    send_frame(1'b0, 1);
    wait_drain();
    check("t6_hold", bus.mcu_hold, 0);
    check("t6_err", bus.load_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
